// File: rtl/fft32_out_serializer.sv
// Output end of the 32-point FFT pipeline: captures a whole frame in one cycle and streams it
// out one complex sample per cycle over valid/ready, optionally in bit-reversed lane order.
module fft32_out_serializer #(
  parameter int unsigned N      = 16,
  parameter bit          BITREV = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [32*N-1:0] in_r,
  input  logic [32*N-1:0] in_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_r,
  output logic [N-1:0]    out_i,
  output logic [4:0]      out_idx,
  output logic            out_last,
  output logic            ovf
);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e         state_q;
  logic           out_valid_q;
  logic [N-1:0]   out_r_q;
  logic [N-1:0]   out_i_q;
  logic [4:0]     out_idx_q;
  logic           out_last_q;
  logic           ovf_q;

  logic [N-1:0]   mem_r [32];
  logic [N-1:0]   mem_i [32];

  logic           accept_out;
  logic           last_accept;
  logic           frame_take;
  logic [4:0]     nxt_idx;
  logic [4:0]     nxt_lane;

  function automatic logic [4:0] map_slot(input logic [4:0] k);
    if (BITREV) return {k[0], k[1], k[2], k[3], k[4]};
    return k;
  endfunction

  assign accept_out  = out_valid_q && out_ready;
  assign last_accept = accept_out && (out_idx_q == 5'd31);
  // A new frame is only taken when idle or while the final sample leaves (zero-bubble handoff).
  assign in_ready    = (state_q == StIdle) || last_accept;
  assign frame_take  = in_valid && in_ready;
  assign nxt_idx     = out_idx_q + 5'd1;
  assign nxt_lane    = map_slot(nxt_idx);

  // Frame buffer carries no reset; it is always fully rewritten before being read.
  always_ff @(posedge clk) begin
    if (frame_take) begin
      for (int k = 0; k < 32; k++) begin
        mem_r[k] <= in_r[k*N +: N];
        mem_i[k] <= in_i[k*N +: N];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_idx_q   <= 5'd0;
      out_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      ovf_q <= in_valid && !in_ready;
      if (frame_take) begin
        // Slot 0 maps to lane 0 in both orderings, so it is loaded straight from the input.
        state_q     <= StStream;
        out_valid_q <= 1'b1;
        out_idx_q   <= 5'd0;
        out_last_q  <= 1'b0;
        out_r_q     <= in_r[N-1:0];
        out_i_q     <= in_i[N-1:0];
      end else if (last_accept) begin
        state_q     <= StIdle;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else if (accept_out) begin
        out_idx_q  <= nxt_idx;
        out_r_q    <= mem_r[nxt_lane];
        out_i_q    <= mem_i[nxt_lane];
        out_last_q <= (nxt_idx == 5'd31);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign ovf       = ovf_q;

endmodule
